p9_gpio_ctrl: RTL and testbench

APB3-mapped controller for the eleven cape GPIO pads P9_21..P9_31. It sits between the MSS fabric APB bus and the pad wrapper: it drives the wrapper's GPIO_OUT[31:21] and GPIO_OE[31:21] buses and samples its GPIO_IN[31:21] bus. It synchronises the inputs, optionally debounces them, and detects edges to raise a single level interrupt. Atomic set/clear registers let software toggle individual pins without read-modify-write.

---
 rtl/p9_gpio_pkg.sv | 32 +++
 rtl/p9_gpio_in_filter.sv | 79 +++++++
 rtl/p9_gpio_ctrl.sv | 171 +++++++++++++++++
 tb/tb_p9_gpio_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p9_gpio_pkg.sv
// Shared definitions for the P9_21..P9_31 cape GPIO controller.
// Latency: n/a (types, constants and a packing helper only).
// Backpressure: n/a.
//
// Holds the APB register offsets, the pin range that the registers
// occupy on the 32-bit data bus, and the pin-vector type used by
// every file in this block.
package p9_gpio_pkg;

  // Pins live on data bits [MSB:LSB] of every register.
  localparam int LSB   = 21;
  localparam int MSB   = 31;
  localparam int NPINS = MSB - LSB + 1;

  typedef logic [MSB:LSB] pin_vec_t;

  // Byte offsets of the register map (PADDR[1:0] never decoded).
  localparam logic [7:0] ADDR_OUT     = 8'h00;
  localparam logic [7:0] ADDR_OE      = 8'h04;
  localparam logic [7:0] ADDR_IN      = 8'h08;
  localparam logic [7:0] ADDR_RISE_EN = 8'h0C;
  localparam logic [7:0] ADDR_FALL_EN = 8'h10;
  localparam logic [7:0] ADDR_STATUS  = 8'h14;
  localparam logic [7:0] ADDR_OUT_SET = 8'h18;
  localparam logic [7:0] ADDR_OUT_CLR = 8'h1C;

  // Place a pin vector on the 32-bit bus; unused low bits read 0.
  function automatic logic [31:0] to_bus(input pin_vec_t v);
    return {v, {LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/p9_gpio_in_filter.sv
// Per-pin input conditioner: 2-flop synchroniser plus optional debounce.
// Latency: 2 edges pad->filt_o; with debounce, a further DEBOUNCE_CYCLES.
// Backpressure: none; the filter samples every cycle.
//
// Ports:
//   clk_i   fabric clock, rising edge
//   rst_i   synchronous active-high reset (all flops to 0)
//   pad_i   raw asynchronous pad input
//   filt_o  synchronised (and, if built, debounced) pin value
//
// Build option: define P9_GPIO_DEBOUNCE_EN to build the debounce counter.
// Without it the filter is a plain wire after the synchroniser and
// DEBOUNCE_CYCLES has no effect.
module p9_gpio_in_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  output logic filt_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef P9_GPIO_DEBOUNCE_EN
  // Count value reached on the last sample of a qualifying run.
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        filt_q;
  logic        filt_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // cnt_q counts consecutive synced samples that disagree with filt_q.
  // A pin is binary, so "all disagree" means "all equal to each other";
  // any sample that matches filt_q restarts the run from zero.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;
`else
  // Pass-through build: nothing depends on the debounce length.
  if (DEBOUNCE_CYCLES == 0) begin : g_debounce_ignored
  end

  assign filt_o = sync2_q;
`endif

endmodule

// File: rtl/p9_gpio_ctrl.sv
// APB3 GPIO controller for cape pads P9_21..P9_31 with edge interrupt.
// Latency: zero-wait APB; pad->IN 2 edges, pad->STATUS/IRQ 3 edges (no debounce).
// Backpressure: none, PREADY is tied high; bad accesses answer with PSLVERR.
//
// Ports:
//   CLK, RESET             fabric clock, synchronous active-high reset
//   PSEL/PENABLE/PWRITE    APB3 control
//   PADDR[7:0], PWDATA     byte address (bits [1:0] ignored), write data
//   PRDATA, PREADY, PSLVERR APB3 response (PRDATA is 0 outside access phase)
//   GPIO_OUT/GPIO_OE       pad output data / output enable, [31:21]
//   GPIO_IN                raw asynchronous pad inputs, [31:21]
//   IRQ                    level interrupt, OR of STATUS
//
// Build option: P9_GPIO_DEBOUNCE_EN adds a DEBOUNCE_CYCLES debounce per pin.
module p9_gpio_ctrl
  import p9_gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         PSEL,
  input  logic         PENABLE,
  input  logic         PWRITE,
  input  logic [7:0]   PADDR,
  input  logic [31:0]  PWDATA,
  output logic [31:0]  PRDATA,
  output logic         PREADY,
  output logic         PSLVERR,
  output logic [31:21] GPIO_OUT,
  output logic [31:21] GPIO_OE,
  input  logic [31:21] GPIO_IN,
  output logic         IRQ
);

  // ------------------------------------------------------------------
  // Input conditioning, one filter per pin
  // ------------------------------------------------------------------
  pin_vec_t filt_w;

  for (genvar g = LSB; g <= MSB; g++) begin : g_pin
    p9_gpio_in_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filter (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .pad_i  (GPIO_IN[g]),
      .filt_o (filt_w[g])
    );
  end

  // ------------------------------------------------------------------
  // Register state
  // ------------------------------------------------------------------
  pin_vec_t out_q,     out_d;
  pin_vec_t oe_q,      oe_d;
  pin_vec_t rise_en_q, rise_en_d;
  pin_vec_t fall_en_q, fall_en_d;
  pin_vec_t status_q,  status_d;
  pin_vec_t prev_q,    prev_d;

  // ------------------------------------------------------------------
  // APB decode
  // ------------------------------------------------------------------
  logic       access;
  logic       addr_hit;
  logic       addr_ro;
  logic       wr_en;
  logic [7:0] word_addr;
  pin_vec_t   rd_vec;
  pin_vec_t   wd_vec;
  pin_vec_t   clr_vec;

  // Byte lanes below the word and data bits below the pin field carry
  // no meaning in this register map.
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA[LSB-1:0]};

  assign word_addr = {PADDR[7:2], 2'b00};
  assign wd_vec    = PWDATA[MSB:LSB];

  // Reset aborts any transfer in flight: no response data, no commit.
  assign access = PSEL & PENABLE & ~RESET;

  always_comb begin
    addr_hit = 1'b1;
    addr_ro  = 1'b0;
    rd_vec   = '0;
    case (word_addr)
      ADDR_OUT:     rd_vec = out_q;
      ADDR_OE:      rd_vec = oe_q;
      ADDR_IN: begin
        rd_vec  = filt_w;
        addr_ro = 1'b1;
      end
      ADDR_RISE_EN: rd_vec = rise_en_q;
      ADDR_FALL_EN: rd_vec = fall_en_q;
      ADDR_STATUS:  rd_vec = status_q;
      ADDR_OUT_SET,
      ADDR_OUT_CLR: rd_vec = '0;
      default:      addr_hit = 1'b0;
    endcase
  end

  assign wr_en   = access & PWRITE & addr_hit & ~addr_ro;
  assign PSLVERR = access & (~addr_hit | (PWRITE & addr_ro));
  assign PRDATA  = access ? to_bus(rd_vec) : '0;
  assign PREADY  = 1'b1;

  // ------------------------------------------------------------------
  // Register write next-state
  // ------------------------------------------------------------------
  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr_vec   = '0;
    if (wr_en) begin
      case (word_addr)
        ADDR_OUT:     out_d     = wd_vec;
        ADDR_OE:      oe_d      = wd_vec;
        ADDR_RISE_EN: rise_en_d = wd_vec;
        ADDR_FALL_EN: fall_en_d = wd_vec;
        ADDR_STATUS:  clr_vec   = wd_vec;
        ADDR_OUT_SET: out_d     = out_q | wd_vec;
        ADDR_OUT_CLR: out_d     = out_q & ~wd_vec;
        default:      ;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Edge detect and sticky status
  // ------------------------------------------------------------------
  pin_vec_t rise_evt;
  pin_vec_t fall_evt;

  assign prev_d   = filt_w;
  assign rise_evt = filt_w & ~prev_q & rise_en_q;
  assign fall_evt = ~filt_w & prev_q & fall_en_q;

  // Events are OR'd in after the clear so a same-cycle event survives a W1C.
  assign status_d = (status_q & ~clr_vec) | rise_evt | fall_evt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      prev_q    <= prev_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign GPIO_OUT = out_q;
  assign GPIO_OE  = oe_q;
  assign IRQ      = |status_q;

endmodule

// File: tb/tb_p9_gpio_ctrl.sv
// Self-checking bench for p9_gpio_ctrl: register table, timed corner
// sequences, then random APB traffic and pad activity against a
// history-based reference model.
module tb_p9_gpio_ctrl;
  import p9_gpio_pkg::*;

`ifdef P9_GPIO_DEBOUNCE_EN
  localparam int DB     = 4;
  localparam int EV_LAT = 2 + DB;
`else
  localparam int DB     = 16;
  localparam int EV_LAT = 2;
`endif

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         PSEL = 1'b0;
  logic         PENABLE = 1'b0;
  logic         PWRITE = 1'b0;
  logic [7:0]   PADDR = '0;
  logic [31:0]  PWDATA = '0;
  logic [31:0]  PRDATA;
  logic         PREADY;
  logic         PSLVERR;
  logic [31:21] GPIO_OUT;
  logic [31:21] GPIO_OE;
  logic [31:21] GPIO_IN = '0;
  logic         IRQ;

  p9_gpio_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK(CLK), .RESET(RESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE),
    .GPIO_IN(GPIO_IN), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  pin_vec_t pad_v = '0;
  logic     rst_v = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pad samples and filtered values are kept as per-edge histories;
  // STATUS follows from comparing filtered values of adjacent edges.
  localparam int HN = 8192;
  pin_vec_t m_pad  [HN];
  pin_vec_t m_filt [HN];
  int       k;
  pin_vec_t m_out, m_oe, m_rise, m_fall, m_stat;

  function automatic int ix(input int i);
    return i & (HN - 1);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < HN; i++) begin
      m_pad[i]  = '0;
      m_filt[i] = '0;
    end
    k = 64;
    m_out = '0; m_oe = '0; m_rise = '0; m_fall = '0; m_stat = '0;
  endtask

  function automatic void m_read(input logic [7:0] a, output logic [31:0] d,
                                 output logic rerr, output logic werr);
    pin_vec_t v;
    v = '0;
    rerr = 1'b0;
    case (a[7:2])
      6'd0: v = m_out;
      6'd1: v = m_oe;
      6'd2: v = m_filt[ix(k)];
      6'd3: v = m_rise;
      6'd4: v = m_fall;
      6'd5: v = m_stat;
      6'd6, 6'd7: v = '0;
      default: rerr = 1'b1;
    endcase
    werr = rerr | (a[7:2] == 6'd2);
    d = {v, 21'b0};
  endfunction

  task automatic m_step();
    pin_vec_t ev, wd, clr, nf, pf;
    logic run;
    if (RESET) begin
      m_reset();
    end else begin
      k++;
      m_pad[ix(k)] = GPIO_IN;
      ev = (m_filt[ix(k-1)] & ~m_filt[ix(k-2)] & m_rise) |
           (~m_filt[ix(k-1)] & m_filt[ix(k-2)] & m_fall);
      clr = '0;
      wd = PWDATA[31:21];
      if (PSEL && PENABLE && PWRITE) begin
        case (PADDR[7:2])
          6'd0: m_out  = wd;
          6'd1: m_oe   = wd;
          6'd3: m_rise = wd;
          6'd4: m_fall = wd;
          6'd5: clr    = wd;
          6'd6: m_out  = m_out | wd;
          6'd7: m_out  = m_out & ~wd;
          default: ;
        endcase
      end
      m_stat = (m_stat & ~clr) | ev;
      pf = m_filt[ix(k-1)];
`ifdef P9_GPIO_DEBOUNCE_EN
      // Filter input at edge k is the pad sampled at edge k-2; it flips
      // once the last DB of those samples all disagree with it.
      nf = pf;
      for (int b = LSB; b <= MSB; b++) begin
        run = 1'b1;
        for (int j = 0; j < DB; j++)
          if (m_pad[ix(k-2-j)][b] == pf[b]) run = 1'b0;
        if (run) nf[b] = ~pf[b];
      end
`else
      run = 1'b0;
      nf = m_pad[ix(k-1)];
`endif
      m_filt[ix(k)] = nf;
    end
  endtask

  // ---------------- stimulus primitives ----------------
  // One clock: drive at negedge, check outputs against the model, then
  // advance the model on the rising edge.
  task automatic cyc(input logic sel, input logic en, input logic wr,
                     input logic [7:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err);
    logic [31:0] ed;
    logic re, we;
    @(negedge CLK);
    RESET = rst_v; PSEL = sel; PENABLE = en; PWRITE = wr;
    PADDR = a; PWDATA = wd; GPIO_IN = pad_v;
    #1;
    rd = PRDATA;
    err = PSLVERR;
    if (!RESET) begin
      chk("m_irq", {31'b0, IRQ}, {31'b0, |m_stat});
      chk("m_gpio_out", {21'b0, GPIO_OUT}, {21'b0, m_out});
      chk("m_gpio_oe", {21'b0, GPIO_OE}, {21'b0, m_oe});
      chk("m_pready", {31'b0, PREADY}, 32'd1);
      if (sel && en) begin
        m_read(a, ed, re, we);
        if (!wr) chk("m_prdata", PRDATA, ed);
        chk("m_pslverr", {31'b0, PSLVERR}, {31'b0, wr ? we : re});
      end else begin
        chk("m_prdata_idle", PRDATA, 32'd0);
      end
    end else begin
      chk("m_prdata_rst", PRDATA, 32'd0);
    end
    @(posedge CLK);
    m_step();
  endtask

  task automatic idle(input int n);
    logic [31:0] r;
    logic e;
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, r, e);
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, output logic err);
    logic [31:0] r;
    logic e;
    cyc(1'b1, 1'b0, 1'b1, a, d, r, e);
    cyc(1'b1, 1'b1, 1'b1, a, d, r, err);
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic err);
    logic [31:0] r;
    logic e;
    cyc(1'b1, 1'b0, 1'b0, a, 32'h0, r, e);
    cyc(1'b1, 1'b1, 1'b0, a, 32'h0, d, err);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [10:0] exp_out;
  } vec_t;

  localparam int NV = 25;
  vec_t tv [NV];

  initial begin
    logic [31:0] rd;
    logic err;
    logic [7:0] ra;

    tv[0]  = '{1'b0, 8'h00, 32'h0,        32'h0,        1'b0, 11'h000};
    tv[1]  = '{1'b0, 8'h04, 32'h0,        32'h0,        1'b0, 11'h000};
    tv[2]  = '{1'b0, 8'h08, 32'h0,        32'h0,        1'b0, 11'h000};
    tv[3]  = '{1'b0, 8'h0C, 32'h0,        32'h0,        1'b0, 11'h000};
    tv[4]  = '{1'b0, 8'h10, 32'h0,        32'h0,        1'b0, 11'h000};
    tv[5]  = '{1'b0, 8'h14, 32'h0,        32'h0,        1'b0, 11'h000};
    tv[6]  = '{1'b0, 8'h18, 32'h0,        32'h0,        1'b0, 11'h000};
    tv[7]  = '{1'b0, 8'h1C, 32'h0,        32'h0,        1'b0, 11'h000};
    tv[8]  = '{1'b0, 8'h20, 32'h0,        32'h0,        1'b1, 11'h000};
    tv[9]  = '{1'b0, 8'hFC, 32'h0,        32'h0,        1'b1, 11'h000};
    tv[10] = '{1'b1, 8'h04, 32'hFFE00000, 32'h0,        1'b0, 11'h000};
    tv[11] = '{1'b1, 8'h00, 32'h00200000, 32'h0,        1'b0, 11'h001};
    tv[12] = '{1'b1, 8'h18, 32'h80000000, 32'h0,        1'b0, 11'h401};
    tv[13] = '{1'b0, 8'h00, 32'h0,        32'h80200000, 1'b0, 11'h401};
    tv[14] = '{1'b1, 8'h1C, 32'h00200000, 32'h0,        1'b0, 11'h400};
    tv[15] = '{1'b0, 8'h00, 32'h0,        32'h80000000, 1'b0, 11'h400};
    tv[16] = '{1'b0, 8'h04, 32'h0,        32'hFFE00000, 1'b0, 11'h400};
    tv[17] = '{1'b1, 8'h08, 32'hFFFFFFFF, 32'h0,        1'b1, 11'h400};
    tv[18] = '{1'b1, 8'h24, 32'hFFFFFFFF, 32'h0,        1'b1, 11'h400};
    tv[19] = '{1'b1, 8'h03, 32'hFFFFFFFF, 32'h0,        1'b0, 11'h7FF};
    tv[20] = '{1'b0, 8'h01, 32'h0,        32'hFFE00000, 1'b0, 11'h7FF};
    tv[21] = '{1'b0, 8'h18, 32'h0,        32'h0,        1'b0, 11'h7FF};
    tv[22] = '{1'b0, 8'h1C, 32'h0,        32'h0,        1'b0, 11'h7FF};
    tv[23] = '{1'b1, 8'h1C, 32'hFFFFFFFF, 32'h0,        1'b0, 11'h000};
    tv[24] = '{1'b0, 8'h00, 32'h0,        32'h0,        1'b0, 11'h000};

    m_reset();
    rst_v = 1'b1;
    idle(3);
    rst_v = 1'b0;
    idle(1);
    chk("rst_irq", {31'b0, IRQ}, 32'd0);
    chk("rst_gpio_oe", {21'b0, GPIO_OE}, 32'd0);

    // ---- register table ----
    for (int i = 0; i < NV; i++) begin
      if (tv[i].wr) begin
        apb_wr(tv[i].a, tv[i].d, err);
      end else begin
        apb_rd(tv[i].a, rd, err);
        chk($sformatf("tv%0d_rdata", i), rd, tv[i].exp_rd);
      end
      chk($sformatf("tv%0d_pslverr", i), {31'b0, err}, {31'b0, tv[i].exp_err});
      #1;
      chk($sformatf("tv%0d_gpio_out", i), {21'b0, GPIO_OUT}, {21'b0, tv[i].exp_out});
    end
    chk("tbl_gpio_oe", {21'b0, GPIO_OE}, 32'h7FF);

    // ---- rise interrupt on pin 25, exact latency ----
    apb_wr(8'h0C, 32'h02000000, err);
    pad_v[25] = 1'b1;
    idle(1);
    for (int i = 1; i <= EV_LAT; i++) begin
      idle(1);
      #1;
      if (i == EV_LAT - 1) chk("rise25_irq_early", {31'b0, IRQ}, 32'd0);
      if (i == EV_LAT)     chk("rise25_irq_on", {31'b0, IRQ}, 32'd1);
    end
    apb_rd(8'h14, rd, err);
    chk("rise25_status", rd, 32'h02000000);
    apb_rd(8'h08, rd, err);
    chk("rise25_in", rd, 32'h02000000);
    apb_wr(8'h14, 32'h02000000, err);
    #1;
    chk("rise25_irq_cleared", {31'b0, IRQ}, 32'd0);

    // ---- fall only on pin 30 ----
    apb_wr(8'h0C, 32'h0, err);
    apb_wr(8'h10, 32'h40000000, err);
    pad_v[30] = 1'b1;
    idle(EV_LAT + 2);
    apb_rd(8'h14, rd, err);
    chk("fall30_rise_ignored", rd, 32'h0);
    apb_rd(8'h08, rd, err);
    chk("fall30_in_high", rd, 32'h42000000);
    pad_v[30] = 1'b0;
    idle(EV_LAT + 2);
    apb_rd(8'h14, rd, err);
    chk("fall30_status", rd, 32'h40000000);
    chk("fall30_irq", {31'b0, IRQ}, 32'd1);
    apb_wr(8'h14, 32'h40000000, err);

    // ---- event and W1C on the same edge, pin 22 ----
    apb_wr(8'h10, 32'h0, err);
    apb_wr(8'h0C, 32'h00400000, err);
    pad_v[22] = 1'b1;
    idle(1);
    idle(EV_LAT - 2);
    apb_wr(8'h14, 32'h00400000, err);
    #1;
    chk("coll22_irq", {31'b0, IRQ}, 32'd1);
    apb_rd(8'h14, rd, err);
    chk("coll22_status", rd, 32'h00400000);
    apb_wr(8'h14, 32'h00400000, err);
    apb_rd(8'h14, rd, err);
    chk("coll22_cleared", rd, 32'h0);

`ifdef P9_GPIO_DEBOUNCE_EN
    // ---- debounce on pin 27 ----
    apb_wr(8'h0C, 32'h08000000, err);
    pad_v[27] = 1'b1;
    idle(DB - 1);
    pad_v[27] = 1'b0;
    idle(10);
    apb_rd(8'h08, rd, err);
    chk("db27_short_in", rd, 32'h02400000);
    apb_rd(8'h14, rd, err);
    chk("db27_short_status", rd, 32'h0);
    pad_v[27] = 1'b1;
    idle(DB + 4);
    apb_rd(8'h08, rd, err);
    chk("db27_long_in", rd, 32'h0A400000);
    apb_rd(8'h14, rd, err);
    chk("db27_long_status", rd, 32'h08000000);
    apb_wr(8'h14, 32'h08000000, err);
    pad_v[27] = 1'b0;
    idle(DB + 4);
`endif

    // ---- reset mid-transfer with pin 21 held high ----
    apb_wr(8'h0C, 32'h0, err);
    pad_v[21] = 1'b1;
    idle(EV_LAT + 2);
    cyc(1'b1, 1'b0, 1'b0, 8'h04, 32'h0, rd, err);
    rst_v = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 8'h04, 32'h0, rd, err);
    chk("rst_mid_prdata", rd, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 8'h0C, 32'hFFFFFFFF, rd, err);
    cyc(1'b1, 1'b1, 1'b1, 8'h0C, 32'hFFFFFFFF, rd, err);
    chk("rst_mid_pslverr", {31'b0, err}, 32'd0);
    rst_v = 1'b0;
    idle(EV_LAT + 3);
    apb_rd(8'h04, rd, err);
    chk("rst2_oe", rd, 32'h0);
    apb_rd(8'h0C, rd, err);
    chk("rst2_rise_en", rd, 32'h0);
    apb_rd(8'h14, rd, err);
    chk("rst2_status", rd, 32'h0);
    apb_rd(8'h08, rd, err);
    chk("rst2_in", rd, 32'h42600000 & 32'h02600000);

    // ---- random traffic against the model ----
    for (int it = 0; it < 700; it++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          for (int b = LSB; b <= MSB; b++)
            if ($urandom_range(0, 7) == 0) pad_v[b] = ~pad_v[b];
          idle(1 + $urandom_range(0, 7));
        end
        2: begin
          ra = 8'($urandom_range(0, 10) * 4 + $urandom_range(0, 3));
          apb_rd(ra, rd, err);
        end
        3: begin
          case ($urandom_range(0, 5))
            0: ra = 8'h00;
            1: ra = 8'h04;
            2: ra = 8'h0C;
            3: ra = 8'h10;
            4: ra = 8'h18;
            default: ra = 8'h1C;
          endcase
          apb_wr(ra, $urandom, err);
        end
        4: apb_wr(8'h14, $urandom, err);
        default: begin
          ra = ($urandom_range(0, 1) == 0) ? 8'h08 : 8'($urandom_range(8, 63) * 4);
          apb_wr(ra, $urandom, err);
        end
      endcase
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
